// File: rtl/bus_master_8088.sv
// 8088 minimum-mode bus initiator: turns single-byte valid/ready requests into
// T1-T2-T3-(Tw)-T4 cycles with READY wait states and a wait-state timeout abort.
module bus_master_8088 #(
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_io,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ALE,
  output logic              RD,
  output logic              WR,
  output logic              MIO,
  input  logic              READY,
  output logic [ADDR_W-1:0] Address,
  inout  wire  [DATA_W-1:0] Data
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  localparam logic [5:0] ST_TI = 6'b000001;
  localparam logic [5:0] ST_T1 = 6'b000010;
  localparam logic [5:0] ST_T2 = 6'b000100;
  localparam logic [5:0] ST_T3 = 6'b001000;
  localparam logic [5:0] ST_TW = 6'b010000;
  localparam logic [5:0] ST_T4 = 6'b100000;

  logic [5:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              io_q, io_d;
  logic              accept;
  logic              strobe;
  logic              data_oe;

  assign req_ready = (state_q == ST_TI) || (state_q == ST_T4);
  assign accept    = req_valid && req_ready;
  assign strobe    = (state_q == ST_T2) || (state_q == ST_T3) || (state_q == ST_TW);
  assign data_oe   = write_q && (strobe || (state_q == ST_T4));

  assign ALE       = (state_q == ST_T1);
  assign RD        = !(strobe && !write_q);
  assign WR        = !(strobe && write_q);
  assign MIO       = !io_q;
  assign Address   = addr_q;
  assign Data      = data_oe ? wdata_q : 'z;
  assign rsp_valid = (state_q == ST_T4);
  assign rsp_err   = (state_q == ST_T4) && err_q;
  assign rsp_rdata = rdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    io_d    = io_q;
    case (state_q)
      ST_TI: if (accept) state_d = ST_T1;
      ST_T1: state_d = ST_T2;
      ST_T2: state_d = ST_T3;
      ST_T3: begin
        if (READY) begin
          state_d = ST_T4;
          err_d   = 1'b0;
          if (!write_q) rdata_d = Data;
        end else begin
          state_d = ST_TW;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_TW: begin
        if (READY) begin
          state_d = ST_T4;
          err_d   = 1'b0;
          if (!write_q) rdata_d = Data;
        end else if (cnt_q == CNT_MAX) begin
          // Timeout: finish the cycle normally but flag it; reads return zero.
          state_d = ST_T4;
          err_d   = 1'b1;
          if (!write_q) rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_T4:   state_d = accept ? ST_T1 : ST_TI;
      default: state_d = ST_TI;
    endcase
    if (accept) begin
      addr_d  = req_addr;
      wdata_d = req_wdata;
      write_d = req_write;
      io_d    = req_io;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= ST_TI;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      io_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      io_q    <= io_d;
    end
  end

endmodule

// File: tb/tb_bus_master_8088.sv
// Directed bench for bus_master_8088 with a simple byte responder on the bus.
module tb_bus_master_8088;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req_valid, req_ready, req_write, req_io;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;
  logic        ALE, RD, WR, MIO, READY;
  logic [19:0] Address;
  wire  [7:0]  Data;

  logic [7:0]  mem [0:255];
  logic [19:0] last_wr_addr;
  logic [7:0]  last_wr_data;
  int          total = 0;
  int          bad   = 0;

  always #5 CLK = ~CLK;

  bus_master_8088 #(.ADDR_W(20), .DATA_W(8), .MAX_WAIT(15)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_io(req_io),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ALE(ALE), .RD(RD), .WR(WR), .MIO(MIO), .READY(READY),
    .Address(Address), .Data(Data)
  );

  // Undriven bus reads back as all ones.
  pullup (Data);
  assign Data = !RD ? mem[Address[7:0]] : 'z;

  always @(posedge CLK) begin
    if (!WR) begin
      last_wr_addr <= Address;
      last_wr_data <= Data;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0;
    req_addr = '0; req_wdata = '0; READY = 1'b1;
    tick(); tick();
    total++; if (ALE !== 1'b0) begin bad++; $display("FAIL rst_ale got=%b exp=0", ALE); end
    total++; if (RD !== 1'b1) begin bad++; $display("FAIL rst_rd got=%b exp=1", RD); end
    total++; if (WR !== 1'b1) begin bad++; $display("FAIL rst_wr got=%b exp=1", WR); end
    total++; if (MIO !== 1'b1) begin bad++; $display("FAIL rst_mio got=%b exp=1", MIO); end
    total++; if (Address !== 20'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", Address); end
    total++; if (Data !== 8'hFF) begin bad++; $display("FAIL rst_data_float got=%h exp=ff", Data); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rspv got=%b exp=0", rsp_valid); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", rsp_err); end
    total++; if (rsp_rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata got=%h exp=00", rsp_rdata); end
    RESET = 1'b1;
    tick();
  endtask

  task automatic test_read();
    mem[8'h45] = 8'hA5;
    req_addr = 20'h12345; req_write = 1'b0; req_io = 1'b0; req_valid = 1'b1; READY = 1'b1;
    tick(); req_valid = 1'b0;
    total++; if (ALE !== 1'b1) begin bad++; $display("FAIL rd_t1_ale got=%b exp=1", ALE); end
    total++; if (Address !== 20'h12345) begin bad++; $display("FAIL rd_t1_addr got=%h exp=12345", Address); end
    total++; if (MIO !== 1'b1) begin bad++; $display("FAIL rd_t1_mio got=%b exp=1", MIO); end
    total++; if (RD !== 1'b1) begin bad++; $display("FAIL rd_t1_rd got=%b exp=1", RD); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rd_t1_ready got=%b exp=0", req_ready); end
    tick();
    total++; if (ALE !== 1'b0) begin bad++; $display("FAIL rd_t2_ale got=%b exp=0", ALE); end
    total++; if (RD !== 1'b0) begin bad++; $display("FAIL rd_t2_rd got=%b exp=0", RD); end
    total++; if (WR !== 1'b1) begin bad++; $display("FAIL rd_t2_wr got=%b exp=1", WR); end
    tick();
    total++; if (RD !== 1'b0) begin bad++; $display("FAIL rd_t3_rd got=%b exp=0", RD); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_t3_rspv got=%b exp=0", rsp_valid); end
    tick();
    total++; if (RD !== 1'b1) begin bad++; $display("FAIL rd_t4_rd got=%b exp=1", RD); end
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rd_t4_rspv got=%b exp=1", rsp_valid); end
    total++; if (rsp_rdata !== 8'hA5) begin bad++; $display("FAIL rd_t4_rdata got=%h exp=a5", rsp_rdata); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rd_t4_err got=%b exp=0", rsp_err); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rd_t4_ready got=%b exp=1", req_ready); end
    tick();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_ti_rspv got=%b exp=0", rsp_valid); end
    total++; if (Address !== 20'h12345) begin bad++; $display("FAIL rd_ti_addr got=%h exp=12345", Address); end
  endtask

  task automatic test_write_io();
    req_addr = 20'h00080; req_wdata = 8'h3C; req_write = 1'b1; req_io = 1'b1; req_valid = 1'b1;
    READY = 1'b1;
    tick(); req_valid = 1'b0; req_wdata = 8'h00;
    total++; if (MIO !== 1'b0) begin bad++; $display("FAIL wr_t1_mio got=%b exp=0", MIO); end
    total++; if (WR !== 1'b1) begin bad++; $display("FAIL wr_t1_wr got=%b exp=1", WR); end
    total++; if (Data !== 8'hFF) begin bad++; $display("FAIL wr_t1_data_float got=%h exp=ff", Data); end
    tick();
    total++; if (WR !== 1'b0) begin bad++; $display("FAIL wr_t2_wr got=%b exp=0", WR); end
    total++; if (RD !== 1'b1) begin bad++; $display("FAIL wr_t2_rd got=%b exp=1", RD); end
    total++; if (Data !== 8'h3C) begin bad++; $display("FAIL wr_t2_data got=%h exp=3c", Data); end
    tick();
    total++; if (WR !== 1'b0) begin bad++; $display("FAIL wr_t3_wr got=%b exp=0", WR); end
    total++; if (Data !== 8'h3C) begin bad++; $display("FAIL wr_t3_data got=%h exp=3c", Data); end
    tick();
    total++; if (WR !== 1'b1) begin bad++; $display("FAIL wr_t4_wr got=%b exp=1", WR); end
    total++; if (Data !== 8'h3C) begin bad++; $display("FAIL wr_t4_data got=%h exp=3c", Data); end
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL wr_t4_rspv got=%b exp=1", rsp_valid); end
    total++; if (MIO !== 1'b0) begin bad++; $display("FAIL wr_t4_mio got=%b exp=0", MIO); end
    tick();
    total++; if (Data !== 8'hFF) begin bad++; $display("FAIL wr_ti_data_float got=%h exp=ff", Data); end
    total++; if (last_wr_addr !== 20'h00080) begin bad++; $display("FAIL wr_resp_addr got=%h exp=00080", last_wr_addr); end
    total++; if (last_wr_data !== 8'h3C) begin bad++; $display("FAIL wr_resp_data got=%h exp=3c", last_wr_data); end
  endtask

  task automatic test_wait_states();
    mem[8'h10] = 8'h5A;
    req_addr = 20'h00110; req_write = 1'b0; req_io = 1'b0; req_valid = 1'b1; READY = 1'b1;
    tick(); req_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      total++; if (rsp_valid !== (c == 7)) begin bad++; $display("FAIL wait_rspv c=%0d got=%b exp=%b", c, rsp_valid, c == 7); end
      total++; if (RD !== !(c >= 2 && c <= 6)) begin bad++; $display("FAIL wait_rd c=%0d got=%b exp=%b", c, RD, !(c >= 2 && c <= 6)); end
      if (c == 7) begin
        total++; if (rsp_rdata !== 8'h5A) begin bad++; $display("FAIL wait_rdata got=%h exp=5a", rsp_rdata); end
      end
      READY = !(c >= 3 && c <= 5);
      tick();
    end
  endtask

  task automatic test_timeout();
    mem[8'h20] = 8'hC3;
    req_addr = 20'h00120; req_write = 1'b0; req_io = 1'b0; req_valid = 1'b1; READY = 1'b1;
    tick(); req_valid = 1'b0; READY = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      total++; if (rsp_valid !== (c == 19)) begin bad++; $display("FAIL to_rspv c=%0d got=%b exp=%b", c, rsp_valid, c == 19); end
      total++; if (rsp_err !== (c == 19)) begin bad++; $display("FAIL to_err c=%0d got=%b exp=%b", c, rsp_err, c == 19); end
      total++; if (RD !== !(c >= 2 && c <= 18)) begin bad++; $display("FAIL to_rd c=%0d got=%b exp=%b", c, RD, !(c >= 2 && c <= 18)); end
      if (c == 19) begin
        total++; if (rsp_rdata !== 8'h00) begin bad++; $display("FAIL to_rdata got=%h exp=00", rsp_rdata); end
      end
      tick();
    end
    READY = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [19:0] addrs [3];
    logic [7:0]  exp   [3];
    int k, p, cyc;
    logic acc;
    addrs[0] = 20'h00201; addrs[1] = 20'h00202; addrs[2] = 20'h00203;
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    mem[8'h01] = 8'h11; mem[8'h02] = 8'h22; mem[8'h03] = 8'h33; mem[8'hFF] = 8'hEE;
    k = 0; p = 0; cyc = 0;
    req_write = 1'b0; req_io = 1'b0; READY = 1'b1; req_valid = 1'b1; req_addr = addrs[0];
    for (int i = 0; i < 14; i++) begin
      acc = req_valid && req_ready;
      tick();
      cyc++;
      if (acc) k++;
      if (cyc <= 12) begin
        total++; if (ALE !== (cyc % 4 == 1)) begin bad++; $display("FAIL b2b_ale cyc=%0d got=%b exp=%b", cyc, ALE, cyc % 4 == 1); end
      end
      if (rsp_valid === 1'b1) begin
        total++; if (cyc != 4 * (p + 1)) begin bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", cyc, 4 * (p + 1)); end
        if (p < 3) begin
          total++; if (rsp_rdata !== exp[p]) begin bad++; $display("FAIL b2b_rdata p=%0d got=%h exp=%h", p, rsp_rdata, exp[p]); end
        end
        p++;
      end
      req_valid = (k < 3);
      req_addr  = (req_ready && k < 3) ? addrs[k] : 20'hFFFFF;
    end
    req_valid = 1'b0;
    total++; if (p != 3) begin bad++; $display("FAIL b2b_pulses got=%0d exp=3", p); end
  endtask

  task automatic test_reset_mid_write();
    req_addr = 20'h00040; req_wdata = 8'h77; req_write = 1'b1; req_io = 1'b0; req_valid = 1'b1;
    READY = 1'b1;
    tick(); req_valid = 1'b0;
    tick();
    total++; if (WR !== 1'b0) begin bad++; $display("FAIL rstm_t2_wr got=%b exp=0", WR); end
    total++; if (Data !== 8'h77) begin bad++; $display("FAIL rstm_t2_data got=%h exp=77", Data); end
    RESET = 1'b0;
    tick();
    total++; if (WR !== 1'b1) begin bad++; $display("FAIL rstm_wr got=%b exp=1", WR); end
    total++; if (Data !== 8'hFF) begin bad++; $display("FAIL rstm_data_float got=%h exp=ff", Data); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rstm_ready got=%b exp=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rstm_rspv got=%b exp=0", rsp_valid); end
    total++; if (Address !== 20'h0) begin bad++; $display("FAIL rstm_addr got=%h exp=0", Address); end
    RESET = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rstm_post_rspv c=%0d got=%b exp=0", c, rsp_valid); end
      total++; if (WR !== 1'b1) begin bad++; $display("FAIL rstm_post_wr c=%0d got=%b exp=1", c, WR); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_read();
    test_write_io();
    test_wait_states();
    test_timeout();
    test_back_to_back();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
